regfile_sb: RTL and testbench

Parametrised register file with two registered read ports, one write port and a per-register busy scoreboard. Successor of the single-width 32×32 register file, with configurable width and depth, synchronous reset, and a scoreboard for pipeline hazard tracking. It sits between decode (read, issue) and writeback (write, clear).

---
 rtl/regfile_sb.sv | 132 +++++++++++++
 tb/tb_regfile_sb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file: two registered read ports, one write port, busy scoreboard.
// Optional write-through bypass on both read ports when REGFILE_BYPASS_EN is defined.

module regfile_sb_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              set,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy,
  output logic              busy_nx
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Clear on writeback, then set on issue, so a same-cycle issue wins.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (we) begin
      data_d = wdata;
      busy_d = 1'b0;
    end
    if (set) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd_data = data_d;
  assign rd_busy = busy_d;
`else
  assign rd_data = data_q;
  assign rd_busy = busy_q;
`endif
  assign busy_nx = busy_d;
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_out,
  output logic              a_busy,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_out,
  output logic              b_busy,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_we,
  input  logic [DATA_W-1:0] c_in,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              iss_we,
  output logic              busy_any
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] rd_data;
  logic [DEPTH-1:0]             rd_busy;
  logic [DEPTH-1:0]             busy_nx;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_reg
      if (ZERO_REG != 0 && i == 0) begin : g_zero
        // Hard-wired zero register: no storage, never busy.
        assign rd_data[i] = '0;
        assign rd_busy[i] = 1'b0;
        assign busy_nx[i] = 1'b0;
      end else begin : g_cell
        regfile_sb_cell #(.DATA_W(DATA_W)) u_cell (
          .clk     (clk),
          .rst     (rst),
          .we      (c_we && (c_addr == ADDR_W'(i))),
          .set     (iss_we && (iss_addr == ADDR_W'(i))),
          .wdata   (c_in),
          .rd_data (rd_data[i]),
          .rd_busy (rd_busy[i]),
          .busy_nx (busy_nx[i])
        );
      end
    end
  endgenerate

  logic [DATA_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic              a_busy_q, a_busy_d, b_busy_q, b_busy_d;
  logic              busy_any_q, busy_any_d;

  always_comb begin
    a_out_d    = rd_data[a_addr];
    a_busy_d   = rd_busy[a_addr];
    b_out_d    = rd_data[b_addr];
    b_busy_d   = rd_busy[b_addr];
    busy_any_d = |busy_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q    <= '0;
      a_busy_q   <= 1'b0;
      b_out_q    <= '0;
      b_busy_q   <= 1'b0;
      busy_any_q <= 1'b0;
    end else begin
      a_out_q    <= a_out_d;
      a_busy_q   <= a_busy_d;
      b_out_q    <= b_out_d;
      b_busy_q   <= b_busy_d;
      busy_any_q <= busy_any_d;
    end
  end

  assign a_out    = a_out_q;
  assign a_busy   = a_busy_q;
  assign b_out    = b_out_q;
  assign b_busy   = b_busy_q;
  assign busy_any = busy_any_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb (DATA_W=64, ADDR_W=6, ZERO_REG=1), bypass-aware.
module tb_regfile_sb;
  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] a_out;
    logic          a_busy;
    logic [DW-1:0] b_out;
    logic          b_busy;
    logic          busy_any;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] a_addr = '0, b_addr = '0, c_addr = '0, iss_addr = '0;
  logic          c_we = 1'b0, iss_we = 1'b0;
  logic [DW-1:0] c_in = '0;
  logic [DW-1:0] a_out, b_out;
  logic          a_busy, b_busy, busy_any;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DEPTH-1:0][DW-1:0] m_regs = '0;
  logic [DEPTH-1:0]         m_busy = '0;
  exp_t                     exp_q[$];
  exp_t                     e, obs;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_out(a_out), .a_busy(a_busy),
    .b_addr(b_addr), .b_out(b_out), .b_busy(b_busy),
    .c_addr(c_addr), .c_we(c_we), .c_in(c_in),
    .iss_addr(iss_addr), .iss_we(iss_we),
    .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  // Drives one cycle of stimulus, pushes the model's expected outputs, then
  // waits until just after the edge that produces them.
  task automatic step(input logic r, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic cwe, input logic [AW-1:0] c, input logic [DW-1:0] cin,
                      input logic iwe, input logic [AW-1:0] iss);
    logic [DEPTH-1:0][DW-1:0] nregs;
    logic [DEPTH-1:0]         nbusy;
    exp_t                     x;
    nregs = m_regs;
    nbusy = m_busy;
    if (r) begin
      nregs = '0;
      nbusy = '0;
    end else begin
      if (cwe && c != '0) begin nregs[c] = cin; nbusy[c] = 1'b0; end
      if (iwe && iss != '0) nbusy[iss] = 1'b1;
    end
    if (r) x = '0;
    else begin
      x.a_out    = BYP ? nregs[a] : m_regs[a];
      x.a_busy   = BYP ? nbusy[a] : m_busy[a];
      x.b_out    = BYP ? nregs[b] : m_regs[b];
      x.b_busy   = BYP ? nbusy[b] : m_busy[b];
      x.busy_any = |nbusy;
    end
    exp_q.push_back(x);
    m_regs = nregs;
    m_busy = nbusy;
    rst = r; a_addr = a; b_addr = b; c_we = cwe; c_addr = c; c_in = cin;
    iss_we = iwe; iss_addr = iss;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 4; j++) begin
      case (j)
        0: step(1, 5, 5, 0, 0, '0, 0, 0);
        1: step(0, 5, 5, 1, 5, 64'hDEADBEEF, 1, 4);
        2: step(1, 5, 6, 1, 6, 64'h1111, 1, 6);
        default: step(0, 5, 6, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    n_checks++;
    if (a_out !== '0 || a_busy !== 1'b0 || busy_any !== 1'b0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL reset_r5 got a_out=%h a_busy=%b busy_any=%b b_out=%h exp all 0",
               a_out, a_busy, busy_any, b_out);
    end
  endtask

  task automatic test_zero_reg();
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: step(0, 0, 0, 1, 0, 64'h12345678, 1, 0);
        default: step(0, 0, 0, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL zero_reg[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    n_checks++;
    if (a_out !== '0 || b_out !== '0 || a_busy || b_busy || busy_any) begin
      n_fail++;
      $display("FAIL zero_reg_abs got a=%h b=%h busy=%b%b%b exp 0", a_out, b_out,
               a_busy, b_busy, busy_any);
    end
  endtask

  task automatic test_bypass();
    for (int j = 0; j < 3; j++) begin
      case (j)
        0: step(0, 7, 7, 1, 7, 64'hCAFEF00D, 0, 0);
        default: step(0, 7, 7, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bypass[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    n_checks++;
    if (a_out !== 64'hCAFEF00D || b_out !== 64'hCAFEF00D) begin
      n_fail++;
      $display("FAIL bypass_abs got a=%h b=%h exp cafef00d", a_out, b_out);
    end
  endtask

  task automatic test_scoreboard();
    for (int j = 0; j < 5; j++) begin
      case (j)
        0: step(0, 3, 4, 0, 0, '0, 1, 3);
        1: step(0, 3, 3, 0, 0, '0, 0, 0);
        2: step(0, 3, 3, 1, 3, 64'h55, 0, 0);
        default: step(0, 3, 3, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL scoreboard[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    n_checks++;
    if (a_out !== 64'h55 || a_busy !== 1'b0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL scoreboard_abs got a=%h busy=%b any=%b exp 55/0/0", a_out, a_busy, busy_any);
    end
  endtask

  task automatic test_set_wins();
    for (int j = 0; j < 4; j++) begin
      case (j)
        0: step(0, 9, 9, 0, 0, '0, 1, 9);
        1: step(0, 9, 9, 1, 9, 64'h1, 1, 9);
        default: step(0, 9, 9, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL set_wins[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    n_checks++;
    if (a_out !== 64'h1 || a_busy !== 1'b1 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_abs got a=%h busy=%b any=%b exp 1/1/1", a_out, a_busy, busy_any);
    end
  endtask

  task automatic test_reset_midstream();
    for (int j = 0; j < 5; j++) begin
      case (j)
        0: step(0, 10, 11, 0, 0, '0, 1, 10);
        1: step(0, 10, 11, 0, 0, '0, 1, 11);
        2: step(1, 10, 11, 0, 0, '0, 1, 12);
        3: step(0, 10, 11, 1, 10, 64'hABCD, 0, 0);
        default: step(0, 10, 9, 0, 0, '0, 0, 0);
      endcase
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", j, obs, e);
      end
    end
  endtask

  task automatic test_width_depth();
    logic [DW-1:0] pat;
    for (int i = 0; i < DEPTH; i++) begin
      pat = {32'(i), ~32'(i)};
      step(0, AW'(i), AW'(DEPTH - 1 - i), 1, AW'(i), pat, 0, 0);
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL width_wr[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    step(0, 0, 0, 0, 0, '0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < DEPTH; i++) begin
      step(0, AW'(i), AW'((i + 1) % DEPTH), 0, 0, '0, 0, 0);
      void'(exp_q.pop_front());
      pat = (i == 0) ? '0 : {32'(i), ~32'(i)};
      n_checks++;
      if (a_out !== pat) begin
        n_fail++;
        $display("FAIL width_rd_a[%0d] got=%h exp=%h", i, a_out, pat);
      end
      pat = (i == DEPTH - 1) ? '0 : {32'(i + 1), ~32'(i + 1)};
      n_checks++;
      if (b_out !== pat) begin
        n_fail++;
        $display("FAIL width_rd_b[%0d] got=%h exp=%h", i, b_out, pat);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 300; j++) begin
      step((j % 97) == 96, AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
           1'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom},
           1'($urandom), AW'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      obs = {a_out, a_busy, b_out, b_busy, busy_any};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", j, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_set_wins();
    test_reset_midstream();
    test_width_depth();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
